dm_port_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares the single DATA_MEM port between the CPU load/store path and the DSP_CONV1D memory-master interface.
- Sits between BUS_INTERCONNECT's DATA_MEM slave side and DATA_MEM.
- Serialises accesses with round-robin fairness, fixed per-transaction latency and a one-cycle ack pulse to the winning master.

---
 rtl/dm_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/dm_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the DATA_MEM port arbiter.
//   state_t   : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   GNT_*     : grant_o encoding, also used as the one-hot winner code
//   word_addr : byte address to word address (caller truncates to ADDR_WIDTH)
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_DSP  = 2'b10;

   // Drops the byte offset; the upper bits are discarded by the caller's
   // width cast, so out-of-range addresses simply alias.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req        in  [1:0] bit 0 = CPU request, bit 1 = DSP request
//   last_grant in  [1:0] master that won the previous arbitration (GNT_*)
//   gnt        out [1:0] one-hot winner (GNT_CPU / GNT_DSP), GNT_NONE if idle
module rr_arbiter2
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = GNT_NONE;
      case (req)
         2'b01:   gnt = GNT_CPU;
         2'b10:   gnt = GNT_DSP;
         // On a tie the master that did not win last time goes first.
         2'b11:   gnt = (last_grant == GNT_DSP) ? GNT_CPU : GNT_DSP;
         default: gnt = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DATA_MEM port between the CPU load/store path and the
// DSP_CONV1D memory master. Each transaction takes IDLE -> ACCESS -> RESP,
// one cycle each, with a one-cycle ack to the winner in RESP.
// Ports:
//   clk_i, reset_ni                 clock, synchronous active-low reset
//   cpu_re_i/cpu_we_i/cpu_addr_i/cpu_wdata_i   CPU request (held until ack)
//   cpu_rdata_o/cpu_ack_o           CPU read data and completion pulse
//   dsp_req_i/dsp_we_i/dsp_addr_i/dsp_wdata_i  DSP request (held until ack)
//   dsp_rdata_o/dsp_ack_o           DSP read data and completion pulse
//   dm_addr_o/dm_wdata_o/dm_we_o    DATA_MEM word address, data, write enable
//   dm_rdata_i                      DATA_MEM read data
//   grant_o                         current owner (GNT_NONE/GNT_CPU/GNT_DSP)
//   busy_o                          transaction in flight
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  cpu_re_i,
   input  logic                  cpu_we_i,
   input  logic [31:0]           cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_ack_o,
   input  logic                  dsp_req_i,
   input  logic                  dsp_we_i,
   input  logic [31:0]           dsp_addr_i,
   input  logic [DATA_WIDTH-1:0] dsp_wdata_i,
   output logic [DATA_WIDTH-1:0] dsp_rdata_o,
   output logic                  dsp_ack_o,
   output logic [ADDR_WIDTH-1:0] dm_addr_o,
   output logic [DATA_WIDTH-1:0] dm_wdata_o,
   output logic                  dm_we_o,
   input  logic [DATA_WIDTH-1:0] dm_rdata_i,
   output logic [1:0]            grant_o,
   output logic                  busy_o
);

   state_t     state_q, state_d;
   logic [1:0] last_grant_q;
   logic [1:0] req;
   logic [1:0] pick;
   logic       start;
   logic       complete;
   logic       we_q;

   // A CPU write takes precedence over a simultaneous CPU read.
   assign req = {dsp_req_i, cpu_re_i | cpu_we_i};

   rr_arbiter2 u_rr (
      .req        (req),
      .last_grant (last_grant_q),
      .gnt        (pick)
   );

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = ACCESS;
               start   = 1'b1;
            end
         end
         ACCESS: begin
            state_d  = RESP;
            complete = 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The dm_* output registers double as the transaction latch: they are
   // loaded only when a winner is picked, so requester inputs may change
   // freely once the transaction has started.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         last_grant_q <= GNT_DSP;
         we_q         <= 1'b0;
         grant_o      <= GNT_NONE;
         busy_o       <= 1'b0;
         dm_addr_o    <= '0;
         dm_wdata_o   <= '0;
         dm_we_o      <= 1'b0;
         cpu_ack_o    <= 1'b0;
         dsp_ack_o    <= 1'b0;
         cpu_rdata_o  <= '0;
         dsp_rdata_o  <= '0;
      end else begin
         cpu_ack_o <= 1'b0;
         dsp_ack_o <= 1'b0;
         dm_we_o   <= 1'b0;

         if (start) begin
            grant_o      <= pick;
            busy_o       <= 1'b1;
            last_grant_q <= pick;
            if (pick == GNT_DSP) begin
               dm_addr_o  <= ADDR_WIDTH'(word_addr(dsp_addr_i));
               dm_wdata_o <= dsp_wdata_i;
               dm_we_o    <= dsp_we_i;
               we_q       <= dsp_we_i;
            end else begin
               dm_addr_o  <= ADDR_WIDTH'(word_addr(cpu_addr_i));
               dm_wdata_o <= cpu_wdata_i;
               dm_we_o    <= cpu_we_i;
               we_q       <= cpu_we_i;
            end
         end

         // Read data is captured on the ACCESS -> RESP edge, alongside the ack.
         if (complete) begin
            if (grant_o == GNT_DSP) begin
               dsp_ack_o <= 1'b1;
               if (!we_q) dsp_rdata_o <= dm_rdata_i;
            end else begin
               cpu_ack_o <= 1'b1;
               if (!we_q) cpu_rdata_o <= dm_rdata_i;
            end
         end

         if (state_q == RESP) begin
            grant_o <= GNT_NONE;
            busy_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: scoreboard of expected acks (master, cycle,
// read data) filled as requests are issued and drained as acks appear.
module tb_dm_port_arbiter;
   import dm_arb_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        cpu_re_i = 1'b0;
   logic        cpu_we_i = 1'b0;
   logic [31:0] cpu_addr_i = '0;
   logic [31:0] cpu_wdata_i = '0;
   logic [31:0] cpu_rdata_o;
   logic        cpu_ack_o;
   logic        dsp_req_i = 1'b0;
   logic        dsp_we_i = 1'b0;
   logic [31:0] dsp_addr_i = '0;
   logic [31:0] dsp_wdata_i = '0;
   logic [31:0] dsp_rdata_o;
   logic        dsp_ack_o;
   logic [7:0]  dm_addr_o;
   logic [31:0] dm_wdata_o;
   logic        dm_we_o;
   logic [31:0] dm_rdata_i;
   logic [1:0]  grant_o;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   dm_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .cpu_re_i    (cpu_re_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_ack_o   (cpu_ack_o),
      .dsp_req_i   (dsp_req_i),
      .dsp_we_i    (dsp_we_i),
      .dsp_addr_i  (dsp_addr_i),
      .dsp_wdata_i (dsp_wdata_i),
      .dsp_rdata_o (dsp_rdata_o),
      .dsp_ack_o   (dsp_ack_o),
      .dm_addr_o   (dm_addr_o),
      .dm_wdata_o  (dm_wdata_o),
      .dm_we_o     (dm_we_o),
      .dm_rdata_i  (dm_rdata_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   // DATA_MEM model: write on the clock edge, read data follows the address.
   logic [31:0] mem [256];
   logic        preload = 1'b1;
   always @(posedge clk_i) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (dm_we_o) begin
         mem[dm_addr_o] <= dm_wdata_o;
      end
   end
   assign dm_rdata_i = mem[dm_addr_o];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      bit          dsp;
      logic [31:0] data;
      int          ack_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_mem [256];
   logic [31:0] m_cpu_rd = '0;
   logic [31:0] m_dsp_rd = '0;

   // Reference model: record the expected ack for a request in service order.
   task automatic push(input bit dsp, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_cyc);
      exp_t       e;
      logic [7:0] w;
      w = addr[9:2];
      if (wr) begin
         exp_mem[w] = wdata;
         e.data = dsp ? m_dsp_rd : m_cpu_rd;
      end else begin
         e.data = exp_mem[w];
         if (dsp) m_dsp_rd = exp_mem[w];
         else     m_cpu_rd = exp_mem[w];
      end
      e.dsp = dsp;
      e.ack_cyc = ack_cyc;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      cpu_re_i  = 1'b0;
      cpu_we_i  = 1'b0;
      dsp_req_i = 1'b0;
      dsp_we_i  = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      idle_inputs();
      reset_ni = 1'b0;
      @(negedge clk_i);
      reset_ni = 1'b1;
      m_cpu_rd = '0;
      m_dsp_rd = '0;
      sb.delete();
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      preload = 1'b0;
      reset_ni = 1'b0;
      cpu_re_i = 1'b1; cpu_addr_i = 32'h20;
      dsp_req_i = 1'b1; dsp_addr_i = 32'h24;
      repeat (3) begin
         @(negedge clk_i);
         checks++;
         if ({cpu_ack_o, dsp_ack_o, dm_we_o, busy_o, grant_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ack=%b%b we=%b busy=%b grant=%b, want all 0",
                     cpu_ack_o, dsp_ack_o, dm_we_o, busy_o, grant_o);
         end
         checks++;
         if ({dm_addr_o, dm_wdata_o, cpu_rdata_o, dsp_rdata_o} !== 104'b0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h crd=%h drd=%h, want 0",
                     dm_addr_o, dm_wdata_o, cpu_rdata_o, dsp_rdata_o);
         end
      end
      reset_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (grant_o !== GNT_CPU || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL first_grant got grant=%b busy=%b, want grant=01 busy=1", grant_o, busy_o);
      end
   endtask

   task automatic test_cpu_write_read();
      exp_t e;
      int   c;
      pulse_reset();
      c = cyc;
      cpu_we_i = 1'b1; cpu_addr_i = 32'h10; cpu_wdata_i = 32'hDEADBEEF;
      push(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, c + 2);
      @(negedge clk_i);
      checks++;
      if (dm_we_o !== 1'b1 || dm_addr_o !== 8'h04 || dm_wdata_o !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL cpu_wr_access got we=%b addr=%h wdata=%h, want 1 04 deadbeef",
                  dm_we_o, dm_addr_o, dm_wdata_o);
      end
      for (int k = 0; k < 12 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (dsp_ack_o !== e.dsp || cyc !== e.ack_cyc || cpu_rdata_o !== e.data || dm_we_o !== 1'b0) begin
               failures++;
               $display("FAIL cpu_wr_rd_ack got dsp=%b cyc=%0d rdata=%h we=%b, want dsp=%b cyc=%0d rdata=%h we=0",
                        dsp_ack_o, cyc, cpu_rdata_o, dm_we_o, e.dsp, e.ack_cyc, e.data);
            end
            if (cpu_we_i) begin
               cpu_we_i = 1'b0; cpu_re_i = 1'b1;
               push(1'b0, 1'b0, 32'h10, '0, cyc + 3);
            end else begin
               cpu_re_i = 1'b0;
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL cpu_wr_rd_timeout got pending=%0d, want 0", sb.size());
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      int   c;
      pulse_reset();
      c = cyc;
      cpu_re_i = 1'b1; cpu_addr_i = 32'h20;
      dsp_req_i = 1'b1; dsp_we_i = 1'b0; dsp_addr_i = 32'h24;
      push(1'b0, 1'b0, 32'h20, '0, c + 2);
      push(1'b1, 1'b0, 32'h24, '0, c + 5);
      for (int k = 0; k < 12 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         checks++;
         if (cpu_ack_o && dsp_ack_o) begin
            failures++;
            $display("FAIL sim_both_acks got cpu_ack=1 dsp_ack=1, want at most one");
         end
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (dsp_ack_o !== e.dsp || cyc !== e.ack_cyc ||
                (dsp_ack_o ? dsp_rdata_o : cpu_rdata_o) !== e.data) begin
               failures++;
               $display("FAIL sim_ack got dsp=%b cyc=%0d crd=%h drd=%h, want dsp=%b cyc=%0d rdata=%h",
                        dsp_ack_o, cyc, cpu_rdata_o, dsp_rdata_o, e.dsp, e.ack_cyc, e.data);
            end
            if (cpu_ack_o) cpu_re_i = 1'b0;
            if (dsp_ack_o) dsp_req_i = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sim_timeout got pending=%0d, want 0", sb.size());
      end
   endtask

   task automatic test_fairness();
      exp_t e;
      int   c;
      int   cpu_n;
      int   dsp_n;
      pulse_reset();
      c = cyc;
      cpu_re_i = 1'b1; cpu_addr_i = 32'h30;
      dsp_req_i = 1'b1; dsp_we_i = 1'b0; dsp_addr_i = 32'h34;
      cpu_n = 1; dsp_n = 1;
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 1'b0, 32'h30, '0, c + 2 + 6 * i);
         push(1'b1, 1'b0, 32'h34, '0, c + 5 + 6 * i);
      end
      for (int k = 0; k < 30 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (dsp_ack_o !== e.dsp || cpu_ack_o === e.dsp || cyc !== e.ack_cyc ||
                (dsp_ack_o ? dsp_rdata_o : cpu_rdata_o) !== e.data) begin
               failures++;
               $display("FAIL fair_ack got cpu=%b dsp=%b cyc=%0d, want dsp=%b cyc=%0d rdata=%h",
                        cpu_ack_o, dsp_ack_o, cyc, e.dsp, e.ack_cyc, e.data);
            end
            if (cpu_ack_o) begin
               if (cpu_n < 3) cpu_n++;
               else cpu_re_i = 1'b0;
            end
            if (dsp_ack_o) begin
               if (dsp_n < 3) dsp_n++;
               else dsp_req_i = 1'b0;
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL fair_timeout got pending=%0d, want 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          c;
      int          n;
      bit          wr_tab [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] addr_tab [4] = '{32'h60, 32'h60, 32'h64, 32'h64};
      logic [31:0] data_tab [4] = '{32'hCAFE0000, 32'h0, 32'hCAFE0001, 32'h0};
      pulse_reset();
      c = cyc;
      for (int i = 0; i < 4; i++) push(1'b1, wr_tab[i], addr_tab[i], data_tab[i], c + 2 + 3 * i);
      n = 0;
      dsp_req_i = 1'b1; dsp_we_i = wr_tab[0]; dsp_addr_i = addr_tab[0]; dsp_wdata_i = data_tab[0];
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (dsp_ack_o !== 1'b1 || cpu_ack_o !== 1'b0 || cyc !== e.ack_cyc || dsp_rdata_o !== e.data) begin
               failures++;
               $display("FAIL b2b_ack got dsp=%b cpu=%b cyc=%0d rdata=%h, want dsp=1 cyc=%0d rdata=%h",
                        dsp_ack_o, cpu_ack_o, cyc, dsp_rdata_o, e.ack_cyc, e.data);
            end
            n++;
            if (n < 4) begin
               dsp_we_i = wr_tab[n]; dsp_addr_i = addr_tab[n]; dsp_wdata_i = data_tab[n];
            end else begin
               dsp_req_i = 1'b0;
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_timeout got pending=%0d, want 0", sb.size());
      end
      @(negedge clk_i);
      checks++;
      if (dsp_ack_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_trailing got ack=%b busy=%b, want 0 0", dsp_ack_o, busy_o);
      end
   endtask

   task automatic test_input_change();
      exp_t e;
      int   c;
      pulse_reset();
      c = cyc;
      dsp_req_i = 1'b1; dsp_we_i = 1'b1; dsp_addr_i = 32'h08; dsp_wdata_i = 32'h1;
      push(1'b1, 1'b1, 32'h08, 32'h1, c + 2);
      @(negedge clk_i);
      dsp_addr_i = 32'h0C; dsp_wdata_i = 32'hFF;
      checks++;
      if (dm_we_o !== 1'b1 || dm_addr_o !== 8'h02 || dm_wdata_o !== 32'h1) begin
         failures++;
         $display("FAIL chg_access got we=%b addr=%h wdata=%h, want 1 02 00000001",
                  dm_we_o, dm_addr_o, dm_wdata_o);
      end
      for (int k = 0; k < 10 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (dsp_ack_o !== 1'b1 || cyc !== e.ack_cyc || dsp_rdata_o !== e.data) begin
               failures++;
               $display("FAIL chg_ack got dsp=%b cyc=%0d rdata=%h, want 1 cyc=%0d rdata=%h",
                        dsp_ack_o, cyc, dsp_rdata_o, e.ack_cyc, e.data);
            end
            dsp_req_i = 1'b0; dsp_we_i = 1'b0;
         end
      end
      @(negedge clk_i);
      checks++;
      if (sb.size() != 0 || mem[2] !== exp_mem[2] || mem[3] !== exp_mem[3]) begin
         failures++;
         $display("FAIL chg_mem got pending=%0d w2=%h w3=%h, want 0 %h %h",
                  sb.size(), mem[2], mem[3], exp_mem[2], exp_mem[3]);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int   c;
      pulse_reset();
      cpu_we_i = 1'b1; cpu_addr_i = 32'h50; cpu_wdata_i = 32'h1234_5678;
      @(negedge clk_i);
      checks++;
      if (dm_we_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_access got we=%b, want 1", dm_we_o);
      end
      reset_ni = 1'b0;
      @(negedge clk_i);
      checks++;
      if (dm_we_o !== 1'b0 || cpu_ack_o !== 1'b0 || busy_o !== 1'b0 || grant_o !== GNT_NONE) begin
         failures++;
         $display("FAIL mid_reset got we=%b ack=%b busy=%b grant=%b, want 0 0 0 00",
                  dm_we_o, cpu_ack_o, busy_o, grant_o);
      end
      reset_ni = 1'b1;
      m_cpu_rd = '0;
      c = cyc;
      push(1'b0, 1'b1, 32'h50, 32'h1234_5678, c + 2);
      for (int k = 0; k < 10 && sb.size() > 0; k++) begin
         @(negedge clk_i);
         if (cpu_ack_o || dsp_ack_o) begin
            e = sb.pop_front();
            checks++;
            if (cpu_ack_o !== 1'b1 || cyc !== e.ack_cyc || cpu_rdata_o !== e.data) begin
               failures++;
               $display("FAIL mid_reissue got cpu=%b cyc=%0d rdata=%h, want 1 cyc=%0d rdata=%h",
                        cpu_ack_o, cyc, cpu_rdata_o, e.ack_cyc, e.data);
            end
            cpu_we_i = 1'b0;
         end
      end
      @(negedge clk_i);
      checks++;
      if (sb.size() != 0 || mem[8'h14] !== exp_mem[8'h14]) begin
         failures++;
         $display("FAIL mid_mem got pending=%0d w14=%h, want 0 %h", sb.size(), mem[8'h14], exp_mem[8'h14]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
      test_reset();
      test_cpu_write_read();
      test_simultaneous();
      test_fairness();
      test_back_to_back();
      test_input_change();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
